// File: rtl/scan_pkg.sv
// Shared definitions for the 4-bit scan sequencer: state encoding, code width
// and the two terminal codes, plus small helpers for code stepping.
package scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_DONE  = 2'd2
    } scan_state_t;

    localparam int          CODE_W   = 4;
    localparam logic [3:0]  CODE_MIN = 4'd0;
    localparam logic [3:0]  CODE_MAX = 4'd15;

    // Last code of a pass in the given direction (dir=1 counts down).
    function automatic logic is_terminal(input logic [3:0] code, input logic dir);
        logic term_s;
        if (dir) begin
            term_s = (code == CODE_MIN);
        end else begin
            term_s = (code == CODE_MAX);
        end
        return term_s;
    endfunction

    // Next code in the scan direction; wraps modulo 16.
    function automatic logic [3:0] next_code(input logic [3:0] code, input logic dir);
        logic [3:0] nxt_s;
        if (dir) begin
            nxt_s = code - 4'd1;
        end else begin
            nxt_s = code + 4'd1;
        end
        return nxt_s;
    endfunction

    // First code of a pass in the given direction.
    function automatic logic [3:0] first_code(input logic dir);
        logic [3:0] fc_s;
        if (dir) begin
            fc_s = CODE_MAX;
        end else begin
            fc_s = CODE_MIN;
        end
        return fc_s;
    endfunction

endpackage

// File: rtl/scan_dec_4x16.sv
// 4-to-16 one-hot decoder driven by the scan code select lines (X = MSB).
module scan_dec_4x16 (
    input  logic        X,
    input  logic        Y,
    input  logic        Z,
    input  logic        W,
    output logic [15:0] D
);

    logic [3:0] sel_s;

    assign sel_s = {X, Y, Z, W};

    // One-hot decode of the select code.
    always_comb begin
        D = 16'd0;
        D[sel_s] = 1'b1;
    end

endmodule

// File: rtl/scan_dwell_cnt.sv
// Dwell down-counter: loadable, clearable, stops at zero and flags it.
module scan_dwell_cnt #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               dec,
    output logic [DWELL_W-1:0] count,
    output logic               zero
);

    logic [DWELL_W-1:0] count_r;

    // Counter register: clear beats load, load beats decrement; never wraps below zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {DWELL_W{1'b0}};
        end else if (clr) begin
            count_r <= {DWELL_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != {DWELL_W{1'b0}})) begin
            count_r <= count_r - {{(DWELL_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign zero  = (count_r == {DWELL_W{1'b0}});

endmodule

// File: rtl/scan_seq_4.sv
// 4-bit code scanner: steps {X,Y,Z,W} through 0..15 (or 15..0), holding each
// code for dwell+1 cycles, in single-pass or continuous mode.
module scan_seq_4
    import scan_pkg::*;
#(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic               dir,
    input  logic [DWELL_W-1:0] dwell,
    output logic               X,
    output logic               Y,
    output logic               Z,
    output logic               W,
    output logic               valid,
    output logic               step,
    output logic               done,
    output logic               busy
);

    scan_state_t        state_r;
    logic [3:0]         code_r;
    logic               valid_r;
    logic               step_r;
    logic               done_r;
    logic               busy_r;
    logic               mode_r;
    logic               dir_r;
    logic [DWELL_W-1:0] dwell_r;

    logic               cnt_clr_s;
    logic               cnt_load_s;
    logic [DWELL_W-1:0] cnt_load_val_s;
    logic               cnt_dec_s;
    logic [DWELL_W-1:0] cnt_count_s;
    logic               cnt_zero_s;
    logic               advance_s;
    logic               accept_s;

    // A start is only honoured in IDLE and only when stop is not also asserted.
    assign accept_s  = start & ~stop;
    // Continuous mode wraps past the terminal code instead of finishing.
    assign advance_s = mode_r | ~is_terminal(code_r, dir_r);

    scan_dwell_cnt #(
        .DWELL_W (DWELL_W)
    ) u_dwell_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr_s),
        .load     (cnt_load_s),
        .load_val (cnt_load_val_s),
        .dec      (cnt_dec_s),
        .count    (cnt_count_s),
        .zero     (cnt_zero_s)
    );

    // Dwell counter control derived from the current state and inputs.
    always_comb begin
        cnt_clr_s      = 1'b0;
        cnt_load_s     = 1'b0;
        cnt_load_val_s = dwell_r;
        cnt_dec_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = dwell;
                end else begin
                    cnt_clr_s = 1'b1;
                end
            end
            ST_DWELL: begin
                if (stop) begin
                    cnt_clr_s = 1'b1;
                end else if (cnt_zero_s) begin
                    if (advance_s) begin
                        cnt_load_s = 1'b1;
                    end else begin
                        cnt_load_s = 1'b0;
                    end
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            ST_DONE: begin
                cnt_clr_s = 1'b1;
            end
            default: begin
                cnt_clr_s = 1'b1;
            end
        endcase
    end

    // Scan FSM with code register and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            code_r  <= CODE_MIN;
            valid_r <= 1'b0;
            step_r  <= 1'b0;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            mode_r  <= 1'b0;
            dir_r   <= 1'b0;
            dwell_r <= {DWELL_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    step_r <= 1'b0;
                    done_r <= 1'b0;
                    if (accept_s) begin
                        state_r <= ST_DWELL;
                        code_r  <= first_code(dir);
                        mode_r  <= mode;
                        dir_r   <= dir;
                        dwell_r <= dwell;
                        valid_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        code_r  <= CODE_MIN;
                        valid_r <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                ST_DWELL: begin
                    if (stop) begin
                        state_r <= ST_IDLE;
                        code_r  <= CODE_MIN;
                        valid_r <= 1'b0;
                        step_r  <= 1'b0;
                        done_r  <= 1'b0;
                        busy_r  <= 1'b0;
                    end else if (cnt_zero_s) begin
                        if (advance_s) begin
                            code_r <= next_code(code_r, dir_r);
                            step_r <= 1'b1;
                        end else begin
                            // Terminal code reached in single-pass mode: code holds.
                            state_r <= ST_DONE;
                            valid_r <= 1'b0;
                            step_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        step_r <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    code_r  <= CODE_MIN;
                    valid_r <= 1'b0;
                    step_r  <= 1'b0;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    code_r  <= CODE_MIN;
                    valid_r <= 1'b0;
                    step_r  <= 1'b0;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign X     = code_r[3];
    assign Y     = code_r[2];
    assign Z     = code_r[1];
    assign W     = code_r[0];
    assign valid = valid_r;
    assign step  = step_r;
    assign done  = done_r;
    assign busy  = busy_r;

endmodule
